// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES job controller slice.
//   aes_job_state_t : controller FSM state (IDLE, START, RUN, HOLD)
//   AES_MODE_DEC/ENC: values carried on in_mode / core_mode
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } aes_job_state_t;

  localparam logic AES_MODE_DEC = 1'b0;
  localparam logic AES_MODE_ENC = 1'b1;

endpackage

// File: rtl/aes_job_controller_if.sv
// Job-side handshakes of the AES job controller.
//   in_*  : job offer (valid/ready) carrying message, key and mode
//   out_* : result slot (valid/ready) carrying result and timeout flag
// master = register block / host side, slave = controller side.
interface aes_job_controller_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEY_W  = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_msg;
  logic [KEY_W-1:0]  in_key;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_msg;
  logic              out_timeout;

  modport master (
    output in_valid, in_msg, in_key, in_mode, out_ready,
    input  in_ready, out_valid, out_msg, out_timeout
  );

  modport slave (
    input  in_valid, in_msg, in_key, in_mode, out_ready,
    output in_ready, out_valid, out_msg, out_timeout
  );
endinterface

// File: rtl/aes_job_controller_watchdog.sv
// RUN-cycle counter with expiry detect.
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous clear to 0 (wins over enable)
//   enable       : count this cycle
//   count        : cycles counted since last clear
//   expire       : count has reached TIMEOUT-1 while enabled
// The counter stops at TIMEOUT-1 when expiring, so it never wraps.
module aes_watchdog #(
  parameter  int unsigned TIMEOUT = 65536,
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/aes_job_controller.sv
// Launches one AES core job per input handshake and returns the result
// (or a timeout marker) over the output handshake.
//   clk, reset_n   : clock, async active-low reset
//   abort          : synchronous return to IDLE from any state
//   job            : job/result handshakes (slave side)
//   core_start     : one-cycle launch pulse
//   core_msg/key/mode : registered job operands, stable START..IDLE
//   core_done/result  : core completion and data
//   cycle_count    : RUN cycles used by the last completed job
//   busy           : controller not idle
module aes_job_controller
  import aes_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W  = 128,
  parameter  int unsigned KEY_W   = 128,
  parameter  int unsigned TIMEOUT = 65536,
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              abort,
  aes_job_controller_if.slave job,
  output logic              core_start,
  output logic [DATA_W-1:0] core_msg,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_mode,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy
);
  aes_job_state_t   state_q, state_d;
  logic             in_ready, out_valid;
  logic             wd_clear, wd_enable, wd_expire;
  logic [CNT_W-1:0] wd_count;

  // core_done masks the watchdog enable so a done on the last RUN cycle
  // wins over expiry and the counter is not advanced on completion.
  aes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .count   (wd_count),
    .expire  (wd_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (job.in_valid) state_d = START;
      end
      START: begin
        core_start = 1'b1;
        wd_clear   = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        wd_enable = !core_done;
        if (core_done || wd_expire) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (job.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      wd_clear = 1'b1;
    end
  end

  assign job.in_ready  = in_ready;
  assign job.out_valid = out_valid;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_msg        <= '0;
      core_key        <= '0;
      core_mode       <= 1'b0;
      job.out_msg     <= '0;
      job.out_timeout <= 1'b0;
      cycle_count     <= '0;
    end else if (!abort) begin
      if (state_q == IDLE && job.in_valid) begin
        core_msg  <= job.in_msg;
        core_key  <= job.in_key;
        core_mode <= job.in_mode;
      end
      if (state_q == RUN) begin
        if (core_done) begin
          job.out_msg     <= core_result;
          job.out_timeout <= 1'b0;
          cycle_count     <= wd_count + CNT_W'(1);
        end else if (wd_expire) begin
          job.out_msg     <= '0;
          job.out_timeout <= 1'b1;
          cycle_count     <= CNT_W'(TIMEOUT);
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_job_controller.sv
module tb_aes_job_controller;
  import aes_ctrl_pkg::*;

  localparam int unsigned DW = 128;
  localparam int unsigned KW = 128;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = $clog2(TO + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          abort = 1'b0;
  logic          core_start;
  logic [DW-1:0] core_msg;
  logic [KW-1:0] core_key;
  logic          core_mode;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic [CW-1:0] cycle_count;
  logic          busy;

  aes_job_controller_if #(.DATA_W(DW), .KEY_W(KW)) job ();

  aes_job_controller #(.DATA_W(DW), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .abort       (abort),
    .job         (job),
    .core_start  (core_start),
    .core_msg    (core_msg),
    .core_key    (core_key),
    .core_mode   (core_mode),
    .core_done   (core_done),
    .core_result (core_result),
    .cycle_count (cycle_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Result the bench expects the DUT to be holding (retained across jobs).
  logic [127:0] last_msg = '0;
  logic         last_to  = 1'b0;
  int           last_cc  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // done_at = index of the RUN cycle (0 = first) on which the core signals
  // done; anything negative or >= TO means the core never answers in time.
  function automatic void model(input int done_at, input logic [127:0] res,
                                output logic [127:0] em, output logic et, output int ec);
    if (done_at >= 0 && done_at < int'(TO)) begin
      em = res; et = 1'b0; ec = done_at + 1;
    end else begin
      em = '0;  et = 1'b1; ec = TO;
    end
  endfunction

  // Called and returns at a negedge with the DUT idle.
  task automatic run_job(input logic [127:0] msg, input logic [127:0] key, input logic mode,
                         input int done_at, input logic [127:0] res, input int stall,
                         input bit done_in_start);
    logic [127:0] em;
    logic         et;
    int           ec;
    int           n;
    model(done_at, res, em, et, ec);
    check("idle_in_ready", job.in_ready, 1);
    job.in_valid = 1'b1; job.in_msg = msg; job.in_key = key; job.in_mode = mode;
    @(negedge clk);
    job.in_valid = 1'b0; job.in_msg = ~msg; job.in_key = ~key; job.in_mode = ~mode;
    check("start_pulse", core_start, 1);
    check("core_msg", core_msg, msg);
    check("core_key", core_key, key);
    check("core_mode", core_mode, mode);
    check("start_in_ready", job.in_ready, 0);
    core_done = done_in_start; core_result = ~res;
    @(negedge clk);
    core_done = 1'b0;
    n = 0;
    while (!job.out_valid && n < int'(TO) + 4) begin
      check("no_restart", core_start, 0);
      check("core_msg_hold", core_msg, msg);
      core_done   = (n == done_at);
      core_result = (n == done_at) ? res : rand128();
      @(negedge clk);
      n++;
    end
    core_done = 1'b0;
    check("latency", n, ec);
    check("out_valid", job.out_valid, 1);
    check("out_msg", job.out_msg, em);
    check("out_timeout", job.out_timeout, et);
    check("cycle_count", cycle_count, ec);
    check("hold_in_ready", job.in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      job.in_valid = 1'b1; job.in_msg = rand128(); job.in_key = rand128();
      @(negedge clk);
      check("bp_out_valid", job.out_valid, 1);
      check("bp_out_msg", job.out_msg, em);
      check("bp_in_ready", job.in_ready, 0);
      check("bp_no_start", core_start, 0);
    end
    job.out_ready = 1'b1;
    @(negedge clk);
    job.out_ready = 1'b0; job.in_valid = 1'b0;
    check("exit_out_valid", job.out_valid, 0);
    check("exit_in_ready", job.in_ready, 1);
    check("exit_no_start", core_start, 0);
    check("retain_out_msg", job.out_msg, em);
    check("retain_cycle_count", cycle_count, ec);
    last_msg = em; last_to = et; last_cc = ec;
  endtask

  initial begin
    job.in_valid = 1'b0; job.in_msg = '0; job.in_key = '0; job.in_mode = 1'b0;
    job.out_ready = 1'b0;

    // Reset values
    #1;
    check("rst_in_ready", job.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", job.out_valid, 0);
    check("rst_out_msg", job.out_msg, 0);
    check("rst_out_timeout", job.out_timeout, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_core_msg", core_msg, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_mode", core_mode, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic job: done 3 cycles after core_start
    run_job(128'h0123456789abcdeffedcba9876543210, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
            AES_MODE_ENC, 2, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 0, 1'b0);
    // Timeout: no done at all
    run_job(rand128(), rand128(), AES_MODE_DEC, -1, rand128(), 0, 1'b0);
    // done on the last RUN cycle wins over expiry
    run_job(rand128(), rand128(), AES_MODE_ENC, int'(TO) - 1, rand128(), 0, 1'b0);
    // Back-pressure for 20 cycles, plus a spurious done during START
    run_job(rand128(), rand128(), AES_MODE_DEC, 4, rand128(), 20, 1'b1);

    // Abort in RUN at counter=4
    job.in_valid = 1'b1; job.in_msg = rand128(); job.in_key = rand128();
    @(negedge clk);
    job.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", job.in_ready, 1);
    check("abort_out_valid", job.out_valid, 0);
    check("abort_out_msg", job.out_msg, last_msg);
    check("abort_out_timeout", job.out_timeout, last_to);
    check("abort_cycle_count", cycle_count, last_cc);
    run_job(rand128(), rand128(), AES_MODE_ENC, 2, rand128(), 0, 1'b0);

    // Accept and abort in the same cycle: job dropped
    job.in_valid = 1'b1; job.in_msg = rand128();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; job.in_valid = 1'b0;
    check("drop_busy", busy, 0);
    check("drop_no_start", core_start, 0);
    @(negedge clk);
    check("drop_no_start2", core_start, 0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      run_job(rand128(), rand128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
              rand128(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of RUN
    job.in_valid = 1'b1; job.in_msg = rand128(); job.in_key = rand128(); job.in_mode = 1'b1;
    @(negedge clk);
    job.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_in_ready", job.in_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_out_msg", job.out_msg, 0);
    check("mrst_cycle_count", cycle_count, 0);
    check("mrst_out_timeout", job.out_timeout, 0);
    check("mrst_core_msg", core_msg, 0);
    check("mrst_core_mode", core_mode, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    core_done = 1'b1; core_result = rand128();
    @(negedge clk);
    core_done = 1'b0;
    check("spur_out_valid", job.out_valid, 0);
    check("spur_busy", busy, 0);
    check("spur_out_msg", job.out_msg, 0);
    @(negedge clk);
    check("spur_cycle_count", cycle_count, 0);
    run_job(rand128(), rand128(), AES_MODE_ENC, 5, rand128(), 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
